// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its load-return FIFO.
package wb_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small load-return FIFO; exposes per-entry valid/address so the top can
// build the pending-destination mask without extra bookkeeping.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  wb_req_t               push_data_i,
    input  logic                  pop_i,
    output logic [CW-1:0]         count_o,
    output wb_req_t               head_o,
    output logic [DEPTH-1:0]      ent_valid_o,
    output logic [DEPTH-1:0][4:0] ent_addr_o
);

    wb_req_t [DEPTH-1:0] mem_q;
    logic    [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic    [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic    [CW-1:0]    count_q, count_d;
    logic    [DEPTH-1:0] valid_q, valid_d;

    // Next-state for pointers, occupancy and per-entry valid bits.
    always_comb begin
        wr_ptr_d = push_i ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_i  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Push and pop never address the same slot: pop needs a non-empty
        // FIFO and push needs a non-full one.
        valid_d           = valid_q;
        valid_d[rd_ptr_q] = valid_q[rd_ptr_q] & ~pop_i;
        valid_d[wr_ptr_q] = valid_d[wr_ptr_q] | push_i;
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign count_o     = count_q;
    assign head_o      = mem_q[rd_ptr_q];
    assign ent_valid_o = valid_q;

    // Per-entry destination address for the pending mask.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr_o[i] = mem_q[i].addr;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win, buffered loads are forced through after
// STARVE_LIMIT lost cycles, and x0 writes are suppressed at the register.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int LD_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            alu_valid_i,
    output logic            alu_ready_o,
    input  logic [4:0]      alu_rd_addr_i,
    input  logic [XLEN-1:0] alu_rd_i,
    input  logic            ld_valid_i,
    output logic            ld_ready_o,
    input  logic [4:0]      ld_rd_addr_i,
    input  logic [XLEN-1:0] ld_rd_i,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_o,
    output logic            wr_o,
    output logic [XLEN-1:0] ld_pend_mask_o
);

    localparam int CW = $clog2(LD_DEPTH) + 1;
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(LD_DEPTH);
    localparam logic [WW-1:0] LIMIT_C = WW'(STARVE_LIMIT);

    logic [CW-1:0]            count_s;
    wb_req_t                  head_s;
    wb_req_t                  push_req_s;
    logic [LD_DEPTH-1:0]      ent_valid_s;
    logic [LD_DEPTH-1:0][4:0] ent_addr_s;
    logic                     push_s, nempty_s, force_ld_s;
    logic                     alu_gnt_s, ld_gnt_s;
    logic [WW-1:0]            wait_q, wait_d;
    logic [4:0]               rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]          rd_q, rd_d;
    logic                     wr_q, wr_d;
    logic [XLEN-1:0]          mask_s;

    assign push_req_s = '{addr: ld_rd_addr_i, data: ld_rd_i};
    assign nempty_s   = (count_s != '0);
    // Space is judged on the current count only; a same-cycle pop does not help.
    assign ld_ready_o = (count_s < DEPTH_C);
    assign push_s     = ld_valid_i && ld_ready_o;
    assign force_ld_s = nempty_s && (wait_q == LIMIT_C);
    assign alu_ready_o = !force_ld_s;
    assign alu_gnt_s  = alu_valid_i && !force_ld_s;
    assign ld_gnt_s   = !alu_gnt_s && nempty_s;

    wb_fifo #(
        .DEPTH (LD_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push_s),
        .push_data_i (push_req_s),
        .pop_i       (ld_gnt_s),
        .count_o     (count_s),
        .head_o      (head_s),
        .ent_valid_o (ent_valid_s),
        .ent_addr_o  (ent_addr_s)
    );

    // Grant mux, x0 filtering and starvation counter next-state.
    always_comb begin
        if (alu_gnt_s) begin
            rd_addr_d = alu_rd_addr_i;
            rd_d      = alu_rd_i;
        end else if (ld_gnt_s) begin
            rd_addr_d = head_s.addr;
            rd_d      = head_s.data;
        end else begin
            rd_addr_d = rd_addr_q;
            rd_d      = rd_q;
        end
        wr_d = (alu_gnt_s || ld_gnt_s) && (rd_addr_d != 5'd0);

        if (!nempty_s || ld_gnt_s) begin
            wait_d = '0;
        end else if (wait_q != LIMIT_C) begin
            wait_d = wait_q + WW'(1);
        end else begin
            wait_d = wait_q;
        end
    end

    // Output register and starvation counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q      <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_q      <= '0;
            wait_q    <= '0;
        end else begin
            wr_q      <= wr_d;
            rd_addr_q <= rd_addr_d;
            rd_q      <= rd_d;
            wait_q    <= wait_d;
        end
    end

    // Pending-destination mask straight from live FIFO entries.
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            mask_s[ent_addr_s[i]] = mask_s[ent_addr_s[i]] | ent_valid_s[i];
        end
        mask_s[0] = 1'b0;
    end

    assign ld_pend_mask_o = mask_s;
    assign rd_addr_o      = rd_addr_q;
    assign rd_o           = rd_q;
    assign wr_o           = wr_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ld_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_addr = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_addr = 5'd0;
    logic [31:0] ld_data = 32'd0;
    logic [4:0]  rd_addr;
    logic [31:0] rd;
    logic        wr;
    logic [31:0] mask;

    int checks = 0;
    int errors = 0;

    // reference model state
    ld_t         mq[$];
    int          m_wait;
    logic        m_wr;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        e_alu_ready, e_ld_ready;
    logic [31:0] e_mask;

    wb_arbiter #(.LD_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .alu_valid_i    (alu_valid),
        .alu_ready_o    (alu_ready),
        .alu_rd_addr_i  (alu_addr),
        .alu_rd_i       (alu_data),
        .ld_valid_i     (ld_valid),
        .ld_ready_o     (ld_ready),
        .ld_rd_addr_i   (ld_addr),
        .ld_rd_i        (ld_data),
        .rd_addr_o      (rd_addr),
        .rd_o           (rd),
        .wr_o           (wr),
        .ld_pend_mask_o (mask)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        mq.delete();
        m_wait = 0;
        m_wr   = 1'b0;
        m_addr = 5'd0;
        m_data = 32'd0;
    endtask

    task automatic model_comb();
        e_ld_ready  = (mq.size() < DEPTH);
        e_alu_ready = !(mq.size() != 0 && m_wait == LIMIT);
        e_mask = 32'd0;
        foreach (mq[i]) e_mask[mq[i].a] = 1'b1;
        e_mask[0] = 1'b0;
    endtask

    task automatic model_edge();
        int n;
        bit frc, ag, lg, acc;
        ld_t e;
        n   = mq.size();
        frc = (n != 0) && (m_wait == LIMIT);
        ag  = alu_valid && !frc;
        lg  = !ag && (n != 0);
        acc = ld_valid && (n < DEPTH);
        if (ag) begin
            m_wr = (alu_addr != 5'd0); m_addr = alu_addr; m_data = alu_data;
        end else if (lg) begin
            e = mq.pop_front();
            m_wr = (e.a != 5'd0); m_addr = e.a; m_data = e.d;
        end else begin
            m_wr = 1'b0;
        end
        if (acc) mq.push_back('{a: ld_addr, d: ld_data});
        if (n == 0 || lg) m_wait = 0;
        else if (m_wait < LIMIT) m_wait = m_wait + 1;
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        @(negedge clk);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_valid = lv; ld_addr = la; ld_data = ld;
        #1;
        model_comb();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            tick();
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_ni = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
            checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", wr); end
            checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
            checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready: got %b want 1", alu_ready); end
            checks++; if (mask !== 32'd0) begin errors++; $display("FAIL reset_mask: got %h want 0", mask); end
            checks++; if (rd_addr !== 5'd0 || rd !== 32'd0) begin errors++; $display("FAIL reset_out: got %0d/%h want 0/0", rd_addr, rd); end
        end
        @(negedge clk);
        alu_valid = 1'b0; ld_valid = 1'b0; rst_ni = 1'b1;
        #1; model_comb();
        tick();
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL post_reset_idle_wr: got %b want 0", wr); end
        drive(1'b1, 5'd3, 32'h0000_0011, 1'b0, 5'd0, 32'd0);
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL first_accept_wr_early: got %b want 0", wr); end
        tick();
        checks++; if (wr !== 1'b1 || rd_addr !== 5'd3 || rd !== 32'h0000_0011) begin
            errors++; $display("FAIL first_alu_write: got wr=%b x%0d %h want wr=1 x3 00000011", wr, rd_addr, rd); end
    endtask

    task automatic test_alu_only();
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %b want 1", alu_ready); end
        tick();
        checks++; if (wr !== 1'b1 || rd_addr !== 5'd5 || rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL alu_x5: got wr=%b x%0d %h want wr=1 x5 deadbeef", wr, rd_addr, rd); end
        drive(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
        tick();
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL alu_x0_filter: got wr=%b want 0", wr); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL idle_no_write: got wr=%b want 0", wr); end
    endtask

    task automatic test_load_idle();
        drain();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA5A5_A5A5);
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b want 1", ld_ready); end
        tick();
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL load_early_write: got wr=%b want 0", wr); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++; if (mask !== 32'h0000_0080) begin errors++; $display("FAIL load_mask_set: got %h want 00000080", mask); end
        tick();
        checks++; if (wr !== 1'b1 || rd_addr !== 5'd7 || rd !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL load_write: got wr=%b x%0d %h want wr=1 x7 a5a5a5a5", wr, rd_addr, rd); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++; if (mask !== 32'd0) begin errors++; $display("FAIL load_mask_clear: got %h want 0", mask); end
        tick();
    endtask

    task automatic test_full_fifo();
        logic [4:0] seen[$];
        int nxt;
        logic lv;
        drain();
        nxt = 1;
        for (int c = 0; c < 40; c++) begin
            lv = (nxt <= 3);
            drive(1'b1, 5'd20, 32'(c), lv, 5'(nxt), 32'hC0DE_0000 + 32'(nxt));
            if (c == 2) begin
                checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL full_ready_third: got %b want 0", ld_ready); end
            end
            checks++; if (ld_ready !== e_ld_ready || alu_ready !== e_alu_ready) begin
                errors++; $display("FAIL full_handshake c%0d: got ld=%b alu=%b want ld=%b alu=%b", c, ld_ready, alu_ready, e_ld_ready, e_alu_ready); end
            if (lv && e_ld_ready) nxt++;
            tick();
            checks++; if (wr !== m_wr || rd_addr !== m_addr || rd !== m_data) begin
                errors++; $display("FAIL full_out c%0d: got %b x%0d %h want %b x%0d %h", c, wr, rd_addr, rd, m_wr, m_addr, m_data); end
            if (wr === 1'b1 && rd_addr >= 5'd1 && rd_addr <= 5'd3) seen.push_back(rd_addr);
        end
        checks++;
        if (seen.size() != 3) begin
            errors++; $display("FAIL full_order_count: got %0d loads want 3", seen.size());
        end else if (seen[0] !== 5'd1 || seen[1] !== 5'd2 || seen[2] !== 5'd3) begin
            errors++; $display("FAIL full_order: got x%0d x%0d x%0d want x1 x2 x3", seen[0], seen[1], seen[2]);
        end
    endtask

    task automatic test_starvation();
        drain();
        drive(1'b1, 5'd21, 32'h0000_0100, 1'b1, 5'd9, 32'h0000_0099);
        tick();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 5'd21, 32'h0000_0100 + 32'(i), 1'b0, 5'd0, 32'd0);
            checks++; if (alu_ready !== (i != 5)) begin
                errors++; $display("FAIL starve_alu_ready c%0d: got %b want %b", i, alu_ready, (i != 5)); end
            tick();
            if (i == 5) begin
                checks++; if (wr !== 1'b1 || rd_addr !== 5'd9 || rd !== 32'h0000_0099) begin
                    errors++; $display("FAIL starve_load_write: got %b x%0d %h want 1 x9 00000099", wr, rd_addr, rd); end
            end
            if (i == 6) begin
                checks++; if (wr !== 1'b1 || rd_addr !== 5'd21 || rd !== 32'h0000_0106) begin
                    errors++; $display("FAIL starve_alu_resume: got %b x%0d %h want 1 x21 00000106", wr, rd_addr, rd); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        drain();
        drive(1'b1, 5'd22, 32'h1, 1'b1, 5'd11, 32'hBBBB_0011);
        tick();
        drive(1'b1, 5'd22, 32'h2, 1'b1, 5'd12, 32'hBBBB_0012);
        tick();
        drive(1'b1, 5'd22, 32'h3, 1'b0, 5'd0, 32'd0);
        checks++; if (mask !== 32'h0000_1800) begin errors++; $display("FAIL midflight_mask: got %h want 00001800", mask); end
        #1;
        rst_ni = 1'b0;
        #1;
        model_reset();
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL midflight_wr_async: got %b want 0", wr); end
        checks++; if (mask !== 32'd0) begin errors++; $display("FAIL midflight_mask_clr: got %h want 0", mask); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL midflight_ld_ready: got %b want 1", ld_ready); end
        @(negedge clk);
        alu_valid = 1'b0; ld_valid = 1'b0; rst_ni = 1'b1;
        #1; model_comb();
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            tick();
            checks++; if (wr !== 1'b0) begin errors++; $display("FAIL midflight_stale_write c%0d: got wr=%b x%0d want 0", i, wr, rd_addr); end
        end
    endtask

    task automatic test_random();
        logic pv;
        logic [4:0] pa;
        logic [31:0] pd;
        int alu_pct;
        pv = 1'b0; pa = 5'd0; pd = 32'd0;
        for (int c = 0; c < 600; c++) begin
            alu_pct = ((c / 100) % 2 == 0) ? 90 : 40;
            if (!pv && $urandom_range(99, 0) < 50) begin
                pv = 1'b1; pa = 5'($urandom_range(31, 0)); pd = $urandom;
            end
            drive(($urandom_range(99, 0) < alu_pct), 5'($urandom_range(31, 0)), $urandom, pv, pa, pd);
            checks++; if (alu_ready !== e_alu_ready) begin errors++; $display("FAIL rnd_alu_ready c%0d: got %b want %b", c, alu_ready, e_alu_ready); end
            checks++; if (ld_ready !== e_ld_ready) begin errors++; $display("FAIL rnd_ld_ready c%0d: got %b want %b", c, ld_ready, e_ld_ready); end
            checks++; if (mask !== e_mask) begin errors++; $display("FAIL rnd_mask c%0d: got %h want %h", c, mask, e_mask); end
            if (pv && e_ld_ready) pv = 1'b0;
            tick();
            checks++; if (wr !== m_wr || rd_addr !== m_addr || rd !== m_data) begin
                errors++; $display("FAIL rnd_out c%0d: got %b x%0d %h want %b x%0d %h", c, wr, rd_addr, rd, m_wr, m_addr, m_data); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_load_idle();
        test_full_fifo();
        test_starvation();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter sitting directly upstream of the integer register file's single write port (`rd_addr`/`rd`/`wr`). It merges two result sources into one registered write per cycle:

- the single-cycle ALU path;
- the variable-latency load-return path, which is buffered in a small FIFO.

ALU results have priority. A starvation counter forces a buffered load through after a bounded wait. Writes to x0 are filtered here, and a pending-destination mask is exported to the issue-stage scoreboard.

## Interface
Parameters:
- `LD_DEPTH`, default 2: load-return FIFO entries, power of two, ≥2.
- `STARVE_LIMIT`, default 4: cycles a non-empty FIFO head may lose arbitration before the ALU is stalled; ≥1.

Ports:
- `clk_i`  in  1  — single clock, all state on rising edge.
- `rst_ni`  in  1  — asynchronous, active-low reset.
- `alu_valid_i`  in  1  — ALU result present.
- `alu_ready_o`  out  1  — ALU result accepted this cycle. Combinational.
- `alu_rd_addr_i`  in  5  — ALU destination.
- `alu_rd_i`  in  32  — ALU result.
- `ld_valid_i`  in  1  — load data present.
- `ld_ready_o`  out  1  — FIFO can accept. Combinational.
- `ld_rd_addr_i`  in  5  — load destination.
- `ld_rd_i`  in  32  — load data.
- `rd_addr_o`  out  5  — register file write address. Registered.
- `rd_o`  out  32  — register file write data. Registered.
- `wr_o`  out  1  — register file write enable. Registered.
- `ld_pend_mask_o`  out  32  — bit k set while any FIFO entry targets xk. Combinational from FIFO contents; bit 0 always 0.

## Operation
FIFO input:
- A load enters the FIFO on `ld_valid_i && ld_ready_o`.
- `ld_ready_o = (count < LD_DEPTH)`. A pop in the same cycle does **not** free space for a push.

Stall condition:
- `force_ld = (count != 0) && (wait_cnt == STARVE_LIMIT)`.
- `alu_ready_o = !force_ld`.

Grant, evaluated each cycle:
- If `alu_valid_i && !force_ld`, the ALU wins.
- Otherwise, if `count != 0`, the FIFO head wins and is popped.
- Otherwise, no grant.

`wait_cnt` (width fits `STARVE_LIMIT`):
- Cleared on any pop or when the FIFO is empty.
- Incremented when the FIFO is non-empty and the head is not granted.
- Saturates at `STARVE_LIMIT`.

Output register, loaded every cycle:
- `rd_addr_o` and `rd_o` take the granted source's fields.
- `wr_o = granted && (addr != 0)`.
- With no grant, `wr_o` is 0 and address/data hold their previous values.
- A granted x0 result is consumed (the FIFO still pops) but `wr_o` stays 0.

Loads entering with `ld_rd_addr_i == 0` are accepted normally and dropped at write time.

Ordering: upstream guarantees that no ALU result targets an rd whose `ld_pend_mask_o` bit is set. This block does not reorder or check same-rd conflicts.

## Timing
Reset (while `rst_ni` is low):
- `wr_o` = 0, `rd_addr_o` = 0, `rd_o` = 0.
- FIFO empty, `wait_cnt` = 0.
- Therefore `ld_ready_o` = 1, `alu_ready_o` = 1, `ld_pend_mask_o` = 0.

Latency:
- ALU: accepted in cycle N → `wr_o` high in cycle N+1.
- Load: accepted in cycle N → earliest `wr_o` in cycle N+2 (FIFO write at edge N, head granted in N+1, registered out at N+2).

Boundaries:
- Full FIFO: `ld_ready_o` = 0; upstream holds its data stable.
- Pointers wrap modulo `LD_DEPTH`.
- Reset asserted mid-operation: FIFO contents and `wait_cnt` are discarded immediately; `wr_o` drops asynchronously.
- During a stall (`force_ld`): `alu_ready_o` = 0 for exactly the one cycle the load is granted; it returns to 1 the following cycle because `wait_cnt` clears on the pop.

## Structure
Package `wb_pkg`:
- `typedef struct packed { logic [4:0] addr; logic [31:0] data; } wb_req_t;`
- `localparam int XLEN = 32;`

Sub-module `wb_fifo`:
- Parameterised on `DEPTH`, storing `wb_req_t`.
- Outputs: count, head, and per-entry valid/addr for the mask.
- Async active-low reset.

Top level contains the arbiter, the starvation counter, and the output register.

## Test plan
- **Reset:** hold `rst_ni` low with random inputs → `wr_o` = 0, `ld_ready_o` = 1, `ld_pend_mask_o` = 0. Release reset → first write appears only one cycle after the first ALU accept.
- **ALU only:** ALU writes `{x5, 0xDEADBEEF}` in cycle 3 → `wr_o` = 1, `rd_addr_o` = 5, `rd_o` = 0xDEADBEEF in cycle 4. Repeat with `{x0, 0x1234}` → `wr_o` = 0.
- **Load, idle ALU:** load `{x7, 0xA5A5A5A5}` in cycle 10 → `ld_pend_mask_o[7]` = 1 in cycles 11–11, write of x7 appears in cycle 12, mask bit clears in cycle 12.
- **Full FIFO:** with `alu_valid_i` held high, push two loads (x1, x2) → `ld_ready_o` = 0 on the third attempt. No load is lost; writes retire in order x1 then x2.
- **Starvation (`STARVE_LIMIT` = 4):** ALU valid continuously, one load buffered → `alu_ready_o` = 0 for exactly one cycle, 4 cycles after the load reaches the head. The load is written one cycle later and the ALU resumes.
- **Reset mid-flight:** two loads buffered, pulse `rst_ni` low → mask = 0, no later write of those loads, `ld_ready_o` = 1.
